// File: rtl/shifter_arbiter_pkg.sv
// shifter_pkg: shift-op and result-slot types plus datapath widths shared by shifter_arbiter and shifter
package shifter_pkg;
  localparam int SHIFT_W = 32;
  localparam int SHAMT_W = 5;
  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR, SH_ASR, SH_ROR} sh_op_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if: requester valid/ready ops (req_valid/req_ready/req_a/req_shamt5/req_sh) and result slot (rsp_valid/rsp_ready/rsp_y/rsp_id); master = requesters+consumer, slave = arbiter
interface shifter_arbiter_if import shifter_pkg::*; #(parameter int NREQ = 2, parameter int IDW = $clog2(NREQ)) ();
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0][SHIFT_W-1:0] req_a;
  logic [NREQ-1:0][SHAMT_W-1:0] req_shamt5;
  logic [NREQ-1:0][1:0] req_sh;
  logic rsp_valid;
  logic rsp_ready;
  logic [SHIFT_W-1:0] rsp_y;
  logic [IDW-1:0] rsp_id;
  modport master (output req_valid, req_a, req_shamt5, req_sh, rsp_ready, input req_ready, rsp_valid, rsp_y, rsp_id);
  modport slave (input req_valid, req_a, req_shamt5, req_sh, rsp_ready, output req_ready, rsp_valid, rsp_y, rsp_id);
endinterface

// File: rtl/shifter_arbiter_shifter.sv
// shifter: combinational 32-bit LSL/LSR/ASR/ROR; ports a, shamt5, sh in, y out
module shifter import shifter_pkg::*; (
  input  logic [SHIFT_W-1:0] a,
  input  logic [SHAMT_W-1:0] shamt5,
  input  sh_op_t             sh,
  output logic [SHIFT_W-1:0] y
);
  logic [SHIFT_W-1:0] asr;
  assign asr = $signed(a) >>> shamt5;
  assign y = sh == SH_LSL ? a << shamt5 :
             sh == SH_LSR ? a >> shamt5 :
             sh == SH_ASR ? asr : SHIFT_W'({a, a} >> shamt5);
endmodule

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: shares one shifter among NREQ requesters into a one-entry tagged result slot; ports clk, rst_n (sync, active-low), bus (shifter_arbiter_if.slave); define SHIFTER_ARB_RR_EN for round-robin, else fixed lowest-index priority
module shifter_arbiter import shifter_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  shifter_arbiter_if.slave bus
);
  slot_state_t state;
  logic [IDW-1:0] gid;
  logic gv, slot_free, acc;
  logic [SHIFT_W-1:0] sy;
`ifdef SHIFTER_ARB_RR_EN
  logic [IDW-1:0] ptr;
  always_comb begin
    gid = '0;
    gv = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        gid = IDW'((int'(ptr) + k) % NREQ);
        gv = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (acc) ptr <= gid == IDW'(NREQ - 1) ? '0 : gid + 1'b1;
`else
  always_comb begin
    gid = '0;
    gv = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_valid[k]) begin
        gid = IDW'(k);
        gv = 1'b1;
      end
  end
`endif
  assign slot_free = state == SLOT_EMPTY || bus.rsp_ready;
  assign acc = rst_n && gv && slot_free;
  assign bus.req_ready = acc ? NREQ'(1) << gid : '0;
  assign bus.rsp_valid = state == SLOT_FULL;
  shifter u_shifter (
    .a      (bus.req_a[gid]),
    .shamt5 (bus.req_shamt5[gid]),
    .sh     (sh_op_t'(bus.req_sh[gid])),
    .y      (sy)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= SLOT_EMPTY;
      bus.rsp_y <= '0;
      bus.rsp_id <= '0;
    end else begin
      state <= acc ? SLOT_FULL : bus.rsp_ready ? SLOT_EMPTY : state;
      if (acc) begin
        bus.rsp_y <= sy;
        bus.rsp_id <= gid;
      end
    end
endmodule
